vmem_sram_resp: RTL
===================

# vmem_sram_resp

Scratchpad responder for the vector core's data memory port. It sits on the memory side of the vector-unit wrapper and completes `vmem_*` transactions against an internal VMEM_W-wide SRAM array. It implements the req/gnt/rvalid protocol with a fixed, parameterisable response latency, byte-enable writes and address-error reporting. It is used as the vector unit's local memory and as the bench target for that memory interface.

## Interface
- `VMEM_W`, 128: data width in bits; multiple of 32; power of two.
- `BASE_ADDR`, 32'h8000_0000: first byte address of the array; aligned to VMEM_W/8.
- `DEPTH`, 1024: number of VMEM_W-bit words; power of two.
- `LATENCY`, 1: cycles from grant to `rvalid`; legal range 1..4.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  **one clock; reset is synchronous and active-high.**
- `vmem_req_i`  in  1  request valid.
- `vmem_gnt_o`  out  1  request accepted this cycle.
- `vmem_addr_i`  in  32  byte address.
- `vmem_we_i`  in  1  1 = write, 0 = read.
- `vmem_be_i`  in  VMEM_W/8  byte enables; write only.
- `vmem_wdata_i`  in  VMEM_W  write data.
- `vmem_rvalid_o`  out  1  response valid; exactly one per grant.
- `vmem_rdata_o`  out  VMEM_W  read data; 0 for writes and errors.
- `vmem_err_o`  out  1  response carries an error; qualified by `rvalid`.
- `stall_i`  in  1  withholds grant (contention/bench throttle).
- `busy_o`  out  1  at least one response in flight.

## Operation
- Grant is combinational: `gnt = req & ~stall_i & ~rst_i`. A transaction is the cycle with `req & gnt`.
- The initiator holds `req` and all attributes stable until granted. The block does not check this.
- Decode: `off = addr - BASE_ADDR`; `idx = off >> log2(VMEM_W/8)`.
- Error if `addr < BASE_ADDR`, or `idx >= DEPTH`, or `addr[log2(VMEM_W/8)-1:0] != 0`.
- Error transaction: no array access; the response has `err=1`, `rdata=0`.
- Write: at the grant edge, byte k of `mem[idx]` takes `wdata[8k+7:8k]` where `be[k]=1`. Other bytes are unchanged. The response has `err=0`, `rdata=0`.
- Read: `mem[idx]` is sampled at the grant edge and carried down the response pipeline. Its value is fixed at grant; later writes do not alter an in-flight read.
- Read-after-write: a read granted in any cycle after a write's grant returns the written data.
- Response pipeline: LATENCY stages, each holding {valid, err, data}, shifted every cycle. The stage LATENCY output drives `vmem_rvalid_o/err_o/rdata_o` directly from flops.
- Responses return in grant order. One new transaction per cycle is sustained with no bubbles.
- There is no response backpressure; the initiator always accepts `rvalid`.
- `busy_o` = OR of all stage valid bits, including the output stage.
- Array contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Reset values: `vmem_gnt_o=0` while `rst_i=1`. `vmem_rvalid_o=0`, `vmem_err_o=0`, `vmem_rdata_o=0`, `busy_o=0` from the first edge with `rst_i=1`.
- Latency: a transaction granted in cycle t has `rvalid=1` in cycle t+LATENCY, for exactly one cycle.
- Outstanding responses are bounded by LATENCY. No counter overflow is possible.
- `stall_i` and `req` together: no grant, no transaction, pipeline still advances.
- `stall_i` toggling mid-stream only creates bubbles. Order is preserved.
- Reset mid-operation: all in-flight responses are dropped, with no `rvalid` after the reset edge. Writes granted before reset remain in the array.
- Reset asserted in the same cycle as `req`: no grant (reset dominates).
- Errors do not stall the pipeline. An error response may be followed immediately by a valid response.

## Test plan
- Basic write/read, LATENCY=1: write `addr=BASE+0x10`, `be=16'hFFFF`, `wdata=128'h0123..CDEF`; next cycle read the same address. Both requests are granted in their request cycle; the read's `rvalid` comes one cycle after its grant with `rdata=128'h0123..CDEF`, `err=0`.
- Partial write: write `BASE+0x20` with all-`FF`, then write `be=16'h0001`, `wdata=...AA`, then read. Required `rdata=128'hFF..FFAA`.
- Address errors:
  - Read at `BASE+DEPTH*16` gives `rvalid` with `err=1`, `rdata=0`.
  - Write to `BASE+0x4` (misaligned) gives `err=1`, and a read of `BASE+0x0` shows it unchanged.
  - Read at `BASE-16` gives `err=1`.
- Pipelining, LATENCY=3: 4 back-to-back reads of `BASE+0x0..0x30` holding distinct patterns. Required: 4 consecutive `rvalid` cycles starting 3 cycles after the first grant, data in order, `busy_o` high throughout.
- Stall: `req` held with `stall_i=1` for 2 cycles. Required: `gnt=0` for those cycles, then granted on the 3rd; `rvalid` at grant+LATENCY only, exactly once.
- Reset mid-flight, LATENCY=3: grant a read, assert `rst_i` one cycle later. Required: no `rvalid` for the following 5 cycles, `busy_o=0` after the reset edge, and a previously written word is still readable after reset.

Source files
------------

// File: rtl/vmem_sram_resp.sv
// Scratchpad SRAM responder for the vector memory port (req/gnt/rvalid, byte-enable writes, address errors).
// Latency: grant is combinational; response appears LATENCY cycles after grant, from flops.
// Backpressure: stall_i withholds grant; responses cannot be stalled, so at most LATENCY are in flight.
module vmem_sram_resp #(
    parameter int          VMEM_W    = 128,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vmem_req_i,
    output logic                  vmem_gnt_o,
    input  logic [31:0]           vmem_addr_i,
    input  logic                  vmem_we_i,
    input  logic [VMEM_W/8-1:0]   vmem_be_i,
    input  logic [VMEM_W-1:0]     vmem_wdata_i,
    output logic                  vmem_rvalid_o,
    output logic [VMEM_W-1:0]     vmem_rdata_o,
    output logic                  vmem_err_o,
    input  logic                  stall_i,
    output logic                  busy_o
);
    localparam int BW   = VMEM_W / 8;
    localparam int OFFW = $clog2(BW);
    localparam int IDXW = $clog2(DEPTH);

    logic              w_gnt;
    logic [31:0]       w_off;
    logic [31:0]       w_idx_full;
    logic [IDXW-1:0]   w_idx;
    logic              w_err;

    logic [VMEM_W-1:0] r_mem [DEPTH];
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_err;
    logic [VMEM_W-1:0]  r_dat [LATENCY];

    assign w_gnt      = vmem_req_i & ~stall_i & ~rst_i;
    assign w_off      = vmem_addr_i - BASE_ADDR;
    assign w_idx_full = w_off >> OFFW;
    assign w_idx      = w_idx_full[IDXW-1:0];
    // Below-base addresses wrap to huge offsets, but are flagged explicitly for clarity.
    assign w_err      = (vmem_addr_i < BASE_ADDR) | (w_idx_full >= 32'(DEPTH))
                      | (|vmem_addr_i[OFFW-1:0]);

    // Array is deliberately not reset; grant is already blocked during reset.
    always_ff @(posedge clk_i) begin
        if (w_gnt && vmem_we_i && !w_err) begin
            for (int k = 0; k < BW; k++) begin
                if (vmem_be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= vmem_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Read data is captured at grant, so later writes cannot disturb an in-flight read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_gnt;
            r_err[0] <= w_gnt & w_err;
            r_dat[0] <= (w_gnt && !vmem_we_i && !w_err) ? r_mem[w_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign vmem_gnt_o    = w_gnt;
    assign vmem_rvalid_o = r_vld[LATENCY-1];
    assign vmem_err_o    = r_err[LATENCY-1];
    assign vmem_rdata_o  = r_dat[LATENCY-1];
    assign busy_o        = |r_vld;
endmodule
